// File: rtl/bus_rr_rbtr_pkg.sv
// Shared constants for the round-robin bus arbiter.
// State encodings, ID width and default broadcast ID.
package quiz2_lib;

  localparam int ID_W = 8;
  localparam logic [ID_W-1:0] BCAST_DFLT = 8'hFF;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GRANT = 2'd1;
  localparam logic [1:0] ST_DLVR  = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
    S_GRANT = ST_GRANT,
    S_DLVR  = ST_DLVR
  } state_e;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bus_rr_rbtr_rr_pick.sv
// Combinational round-robin picker: first request after lst.
// Double-width rotate followed by a lowest-bit priority encode.
module rr_pick
  import quiz2_lib::*;
#(
  parameter  int N  = 4,
  localparam int IW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] lst,
  output logic [IW-1:0] gnt_idx,
  output logic          any_req
);

  localparam int IW1 = IW + 1;
  localparam logic [IW-1:0] LAST = IW'(N - 1);
  localparam logic [IW:0]   NW   = IW1'(N);

  logic [IW-1:0]  start;
  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  logic [IW-1:0]  off;
  logic [IW:0]    sum;
  logic           unused_hi;

  assign start = (lst == LAST) ? '0 : lst + 1'b1;

  // rot[i] is the request of driver (start + i) mod N
  assign dbl       = {req, req} >> start;
  assign rot       = dbl[N-1:0];
  assign unused_hi = ^dbl[2*N-1:N];
  assign any_req   = |req;

  always_comb begin
    off = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) off = IW'(i);
    end
  end

  assign sum = {1'b0, start} + {1'b0, off};

  assign gnt_idx = (sum >= NW) ? IW'(sum - NW)
                               : sum[IW-1:0];

endmodule

// File: rtl/bus_rr_rbtr.sv
// Round-robin arbiter and transfer sequencer for the driver bus.
// IDLE picks a winner, GRANT pops it, DLVR pushes to destination(s).
module bus_rr_rbtr
  import quiz2_lib::*;
#(
  parameter int              drvr      = 4,
  parameter int              pckg_sz   = 16,
  parameter logic [ID_W-1:0] broadcast = BCAST_DFLT
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [drvr-1:0]           pndng,
  input  logic [drvr*pckg_sz-1:0]   D_pop,
  output logic [drvr-1:0]           pop,
  output logic [drvr-1:0]           push,
  output logic [drvr*pckg_sz-1:0]   D_push,
  output logic                      bs_bsy,
  output logic                      trn_chng,
  output logic                      drp
);

  localparam int IW   = idx_w(drvr);
  localparam int IDW1 = ID_W + 1;
  localparam logic [IW-1:0]   LST_RST = IW'(drvr - 1);
  localparam logic [ID_W:0]   DRVR_N  = IDW1'(drvr);
  localparam logic [drvr-1:0] ONE     = drvr'(1);

  state_e             state_q;
  logic [IW-1:0]      g_q;
  logic [IW-1:0]      lst_q;
  logic [pckg_sz-1:0] bus_q;
  logic [drvr-1:0]    pop_q;
  logic [drvr-1:0]    push_q;
  logic               bsy_q;
  logic               trn_q;
  logic               drp_q;

  logic [IW-1:0]      gnt;
  logic               any;
  logic [pckg_sz-1:0] head;
  logic [ID_W-1:0]    dest;
  logic [ID_W-1:0]    g_id;
  logic [drvr-1:0]    push_d;
  logic               drp_d;

  rr_pick #(
    .N (drvr)
  ) u_pick (
    .req     (pndng),
    .lst     (lst_q),
    .gnt_idx (gnt),
    .any_req (any)
  );

  always_comb begin
    head = '0;
    for (int i = 0; i < drvr; i++) begin
      if (g_q == IW'(i)) head = D_pop[i*pckg_sz +: pckg_sz];
    end
  end

  assign dest = head[pckg_sz-1 -: ID_W];
  assign g_id = ID_W'(g_q);

  // Self-addressed or out-of-range IDs are discarded
  always_comb begin
    push_d = '0;
    drp_d  = 1'b0;
    if (dest == broadcast) begin
      push_d      = '1;
      push_d[g_q] = 1'b0;
    end else if (({1'b0, dest} < DRVR_N) && (dest != g_id)) begin
      push_d[dest[IW-1:0]] = 1'b1;
    end else begin
      drp_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      g_q     <= '0;
      lst_q   <= LST_RST;
      bus_q   <= '0;
      pop_q   <= '0;
      push_q  <= '0;
      bsy_q   <= 1'b0;
      trn_q   <= 1'b0;
      drp_q   <= 1'b0;
    end else begin
      pop_q  <= '0;
      push_q <= '0;
      trn_q  <= 1'b0;
      drp_q  <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (any) begin
            g_q     <= gnt;
            pop_q   <= ONE << gnt;
            bsy_q   <= 1'b1;
            state_q <= S_GRANT;
          end
        end
        S_GRANT: begin
          bus_q   <= head;
          lst_q   <= g_q;
          push_q  <= push_d;
          drp_q   <= drp_d;
          trn_q   <= 1'b1;
          state_q <= S_DLVR;
        end
        S_DLVR: begin
          bsy_q   <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          bsy_q   <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign pop      = pop_q;
  assign push     = push_q;
  assign D_push   = {drvr{bus_q}};
  assign bs_bsy   = bsy_q;
  assign trn_chng = trn_q;
  assign drp      = drp_q;

endmodule

// File: tb/tb_bus_rr_rbtr.sv
// Bench for bus_rr_rbtr: driver FIFOs as queues, cycle-level
// transaction model, directed scenarios then random traffic.
module tb_bus_rr_rbtr;

  localparam int N = 4;
  localparam int W = 16;

  typedef logic [W-1:0] pq_t[$];

  logic           clk    = 1'b0;
  logic           rst    = 1'b1;
  logic [N-1:0]   pndng  = '0;
  logic [N*W-1:0] D_pop  = '0;
  logic [N-1:0]   pop;
  logic [N-1:0]   push;
  logic [N*W-1:0] D_push;
  logic           bs_bsy;
  logic           trn_chng;
  logic           drp;

  int checks   = 0;
  int failures = 0;

  pq_t          q[N];
  int           ph    = 0;
  int           m_lst = N - 1;
  int           m_w   = 0;
  logic [W-1:0] m_pkt = '0;
  int           glog[$];
  logic [N-1:0] plog[$];
  logic         dlog[$];

  always #5 clk = ~clk;

  bus_rr_rbtr #(
    .drvr      (N),
    .pckg_sz   (W),
    .broadcast (8'hFF)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .pndng    (pndng),
    .D_pop    (D_pop),
    .pop      (pop),
    .push     (push),
    .D_push   (D_push),
    .bs_bsy   (bs_bsy),
    .trn_chng (trn_chng),
    .drp      (drp)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit busy_f();
    bit b = 1'b0;
    for (int i = 0; i < N; i++) if (q[i].size() != 0) b = 1'b1;
    return b;
  endfunction

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      pndng[i] = (q[i].size() != 0);
      D_pop[i*W +: W] = (q[i].size() != 0) ? q[i][0] : '0;
    end
  endtask

  // {drop, push mask} the spec's delivery rules give for pkt from src
  function automatic logic [N:0] exp_dlv(input logic [W-1:0] pkt,
                                         input int src);
    int           dst;
    logic [N-1:0] m;
    logic         d;
    dst = int'(pkt[W-1 -: 8]);
    m   = '0;
    d   = 1'b0;
    if (dst == 255) begin
      for (int j = 0; j < N; j++) m[j] = (j != src);
    end else if (dst < N && dst != src) begin
      m[dst] = 1'b1;
    end else begin
      d = 1'b1;
    end
    return {d, m};
  endfunction

  task automatic chk_zero(input string tag);
    chk({tag, "_pop"}, 64'(pop), 64'(0));
    chk({tag, "_push"}, 64'(push), 64'(0));
    chk({tag, "_bsy"}, 64'(bs_bsy), 64'(0));
    chk({tag, "_trn"}, 64'(trn_chng), 64'(0));
    chk({tag, "_drp"}, 64'(drp), 64'(0));
    chk({tag, "_dpush"}, 64'(D_push), 64'(0));
  endtask

  task automatic model_step();
    logic [N:0] e;
    case (ph)
      0: begin
        chk("idle_pop", 64'(pop), 64'(0));
        chk("idle_push", 64'(push), 64'(0));
        chk("idle_bsy", 64'(bs_bsy), 64'(0));
        chk("idle_trn", 64'(trn_chng), 64'(0));
        chk("idle_drp", 64'(drp), 64'(0));
        if (pndng != '0) begin
          for (int k = 1; k <= N; k++) begin
            int i;
            i = (m_lst + k) % N;
            if (pndng[i]) begin
              m_w = i;
              break;
            end
          end
          m_pkt = q[m_w][0];
          ph    = 1;
        end
      end
      1: begin
        chk("grant_pop", 64'(pop), 64'(1) << m_w);
        chk("grant_push", 64'(push), 64'(0));
        chk("grant_bsy", 64'(bs_bsy), 64'(1));
        chk("grant_trn", 64'(trn_chng), 64'(0));
        chk("grant_drp", 64'(drp), 64'(0));
        m_lst = m_w;
        glog.push_back(m_w);
        ph = 2;
      end
      default: begin
        e = exp_dlv(m_pkt, m_w);
        chk("dlvr_push", 64'(push), 64'(e[N-1:0]));
        chk("dlvr_drp", 64'(drp), 64'(e[N]));
        chk("dlvr_trn", 64'(trn_chng), 64'(1));
        chk("dlvr_bsy", 64'(bs_bsy), 64'(1));
        chk("dlvr_pop", 64'(pop), 64'(0));
        for (int j = 0; j < N; j++)
          chk("dlvr_data", 64'(D_push[j*W +: W]), 64'(m_pkt));
        plog.push_back(push);
        dlog.push_back(drp);
        ph = 0;
      end
    endcase
  endtask

  task automatic cycle();
    logic [N-1:0] seen;
    @(negedge clk);
    model_step();
    seen = pop;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++)
      if (seen[i] && q[i].size() != 0) void'(q[i].pop_front());
    drive();
  endtask

  task automatic run_drain(input string tag, input int max);
    int n = 0;
    while ((busy_f() || ph != 0) && n < max) begin
      cycle();
      n++;
    end
    chk(tag, 64'(busy_f() || ph != 0), 64'(0));
  endtask

  task automatic do_reset(input int n);
    rst   = 1'b0;
    ph    = 0;
    m_lst = N - 1;
    #1;
    chk_zero("rst_now");
    repeat (n) begin
      @(negedge clk);
      chk_zero("rst_hold");
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic chk_glog(input string tag, input int idx, input int exp);
    int obs;
    obs = (glog.size() > idx) ? glog[idx] : -1;
    chk(tag, 64'(obs), 64'(exp));
  endtask

  function automatic logic [W-1:0] rand_pkt();
    int r;
    logic [7:0] d;
    r = $urandom_range(0, 9);
    if (r < 4)      d = 8'(r);
    else if (r < 6) d = 8'hFF;
    else            d = 8'($urandom_range(4, 254));
    return {d, 8'($urandom_range(0, 255))};
  endfunction

  initial begin
    int n;
    int seq[9];

    // Reset with all drivers pending, then drain in 0,1,2,3 order
    q[0].push_back(16'h0111);
    q[1].push_back(16'h0222);
    q[2].push_back(16'h0333);
    q[3].push_back(16'h0044);
    drive();
    #2;
    do_reset(3);
    glog.delete();
    run_drain("rst_drain", 40);
    for (int i = 0; i < N; i++) chk_glog("rst_order", i, i);

    // Unicast 2 -> 1
    plog.delete();
    q[2].push_back(16'h01AB);
    drive();
    run_drain("uni_drain", 20);
    chk("uni_push", 64'((plog.size() > 0) ? plog[0] : '1),
        64'(4'b0010));

    // Fairness with 1011 held; restart from reset priority
    do_reset(1);
    for (int r = 0; r < 3; r++) begin
      q[0].push_back(16'h0110);
      q[1].push_back(16'h0311);
      q[3].push_back(16'h0033);
    end
    drive();
    glog.delete();
    run_drain("rr_drain", 60);
    seq = '{0, 1, 3, 0, 1, 3, 0, 1, 3};
    for (int i = 0; i < 9; i++) chk_glog("rr_order", i, seq[i]);

    // Broadcast from driver 3
    plog.delete();
    dlog.delete();
    q[3].push_back(16'hFF5A);
    drive();
    run_drain("bc_drain", 20);
    chk("bc_push", 64'((plog.size() > 0) ? plog[0] : '0),
        64'(4'b0111));
    chk("bc_drp", 64'((dlog.size() > 0) ? dlog[0] : 1'b1), 64'(0));

    // Self-addressed and out-of-range drops
    plog.delete();
    dlog.delete();
    q[1].push_back(16'h0133);
    drive();
    run_drain("self_drain", 20);
    q[0].push_back(16'h0900);
    drive();
    run_drain("oor_drain", 20);
    for (int i = 0; i < 2; i++) begin
      chk("drop_push", 64'((plog.size() > i) ? plog[i] : '1), 64'(0));
      chk("drop_drp", 64'((dlog.size() > i) ? dlog[i] : 1'b0), 64'(1));
    end

    // Reset during DLVR kills the push at once
    q[2].push_back(16'h0301);
    drive();
    n = 0;
    while (ph != 2 && n < 20) begin
      cycle();
      n++;
    end
    chk("mid_reach", 64'(ph), 64'(2));
    chk("mid_push_pre", 64'(push), 64'(4'b1000));
    do_reset(1);
    chk("mid_lost", 64'(q[2].size()), 64'(0));
    q[1].push_back(16'h0010);
    q[3].push_back(16'h0020);
    q[0].push_back(16'h0301);
    drive();
    glog.delete();
    run_drain("mid_drain", 30);
    chk_glog("mid_first", 0, 0);
    chk_glog("mid_second", 1, 1);
    chk_glog("mid_third", 2, 3);

    // Random traffic against the model
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 2) == 0) begin
        int d;
        d = $urandom_range(0, N - 1);
        if (q[d].size() < 4) q[d].push_back(rand_pkt());
        drive();
      end
      cycle();
    end
    run_drain("rand_drain", 100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
